// File: rtl/pipe_reg_slice.sv
// pipe_reg_slice: fully registered 2-entry valid/ready pipeline slice.
// valid_o, d_o, ready_o and count_o all come straight from flops, so both the
// forward (valid/data) and backward (ready) timing paths are cut here.
// The main register drives d_o; the skid register catches the word that was
// already in flight when downstream stalled, which is what allows ready_o to
// be registered while still sustaining one transfer per cycle.
module pipe_reg_slice #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic [DATA_LEN-1:0] d_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [DATA_LEN-1:0] d_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [1:0]          count_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_LEN-1:0] skid_q;

  // Handshakes are formed only from registered outputs and raw inputs; nothing
  // here feeds back into ready_o within the same cycle.
  logic xfer_in;
  logic xfer_out;

  assign xfer_in  = valid_i && ready_o;
  assign xfer_out = valid_o && ready_i;

  // Slice control and storage: state, registered flags, main (d_o) and skid data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_EMPTY;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
      count_o <= 2'd0;
      d_o     <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      // Any outgoing transfer this cycle has already completed downstream; the
      // incoming word is dropped. Data registers are left as they are.
      state   <= S_EMPTY;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
      count_o <= 2'd0;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (xfer_in) begin
            d_o     <= d_i;
            state   <= S_HALF;
            valid_o <= 1'b1;
            ready_o <= 1'b1;
            count_o <= 2'd1;
          end
        end
        S_HALF: begin
          if (xfer_in && xfer_out) begin
            // Pass-through: the new word replaces the departing one.
            d_o <= d_i;
          end else if (xfer_in) begin
            // Downstream stalled; park the new word behind the main one.
            skid_q  <= d_i;
            state   <= S_FULL;
            ready_o <= 1'b0;
            count_o <= 2'd2;
          end else if (xfer_out) begin
            state   <= S_EMPTY;
            valid_o <= 1'b0;
            count_o <= 2'd0;
          end
        end
        S_FULL: begin
          // Upstream is held off; only a drain moves state.
          if (xfer_out) begin
            d_o     <= skid_q;
            state   <= S_HALF;
            ready_o <= 1'b1;
            count_o <= 2'd1;
          end
        end
        default: begin
          state   <= S_EMPTY;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          count_o <= 2'd0;
        end
      endcase
    end
  end

endmodule
